text_pixel_renderer: RTL and testbench

//  Parametrised, pipelined successor to the combinational glyph pixel encoder.

---
 rtl/text_pixel_renderer_pkg.sv | 21 ++
 rtl/text_blink_timer.sv | 31 +++
 rtl/text_pixel_renderer.sv | 153 +++++++++++++++
 tb/tb_text_pixel_renderer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/text_pixel_renderer_pkg.sv
// rtl/text_pixel_renderer_pkg.sv - shared widths, colour constants and helpers for the text renderer
package text_pixel_renderer_pkg;

  localparam int RGB_W   = 12;
  localparam int COORD_W = 10;
  localparam int ROW_W   = 4;
  localparam int COL_W   = 6;

  typedef logic [RGB_W-1:0]   rgb_t;
  typedef logic [COORD_W-1:0] coord_t;

  localparam rgb_t COLOR_BLACK      = 12'h000;
  localparam rgb_t COLOR_WHITE      = 12'hFFF;
  localparam rgb_t BG_COLOR_DEFAULT = 12'h00F;

  // Inverse video is a plain bitwise complement of the texel colour.
  function automatic rgb_t invert_rgb(input rgb_t c);
    return c ^ COLOR_WHITE;
  endfunction

endpackage

// File: rtl/text_blink_timer.sv
// rtl/text_blink_timer.sv - counts frame ticks and toggles the cursor blink phase
module text_blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  output logic phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] count;

  // Frame counter wraps at the half-period boundary and flips the phase; reset beats a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      phase <= 1'b0;
    end else if (frame_tick) begin
      if (count == LAST) begin
        count <= '0;
        phase <= ~phase;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_pixel_renderer.sv
// rtl/text_pixel_renderer.sv - five-stage pixel pipe: coordinates -> text buffer -> glyph ROM -> RGB
module text_pixel_renderer
  import text_pixel_renderer_pkg::*;
#(
  parameter int   GLYPH_W_LOG2 = 4,
  parameter int   GLYPH_H_LOG2 = 5,
  parameter int   SCALE_LOG2   = 1,
  parameter int   COLS         = 20,
  parameter int   ROWS         = 7,
  parameter int   CODE_W       = 8,
  parameter rgb_t BG_COLOR     = BG_COLOR_DEFAULT,
  parameter int   BLINK_FRAMES = 30
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   pix_valid,
  input  logic [COORD_W-1:0]                     x,
  input  logic [COORD_W-1:0]                     y,
  input  logic                                   frame_tick,
  input  logic                                   cursor_en,
  input  logic [ROW_W-1:0]                       cursor_row,
  input  logic [COL_W-1:0]                       cursor_col,
  output logic [ROW_W-1:0]                       char_row,
  output logic [COL_W-1:0]                       char_col,
  input  logic [CODE_W-1:0]                      char_code,
  output logic [CODE_W+GLYPH_W_LOG2+GLYPH_H_LOG2-1:0] glyph_addr,
  input  logic [RGB_W-1:0]                       glyph_pixel,
  output logic [RGB_W-1:0]                       rgb,
  output logic                                   rgb_valid
);

  // Texel and cell coordinates kept at full width so off-grid pixels never alias into real cells.
  coord_t tx, ty, cell_col, cell_row;
  logic   in_win_c, is_cur_c;

  always_comb begin
    tx       = x >> SCALE_LOG2;
    ty       = y >> SCALE_LOG2;
    cell_col = tx >> GLYPH_W_LOG2;
    cell_row = ty >> GLYPH_H_LOG2;
    in_win_c = (cell_col < COORD_W'(COLS)) && (cell_row < COORD_W'(ROWS));
    is_cur_c = cursor_en && (cell_row == COORD_W'(cursor_row))
                         && (cell_col == COORD_W'(cursor_col));
  end

  logic [GLYPH_W_LOG2-1:0] lx1, lx2;
  logic [GLYPH_H_LOG2-1:0] ly1, ly2;
  logic [CODE_W-1:0]       code2;
  rgb_t                    pix4;
  logic                    v1, v2, v3, v4;
  logic                    win1, win2, win3, win4;
  logic                    cur1, cur2, cur3, cur4;
  logic                    blink_phase;

  text_blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .phase     (blink_phase)
  );

  // S1: issue the text buffer read and latch the in-cell texel offsets and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      char_row <= '0;
      char_col <= '0;
      lx1      <= '0;
      ly1      <= '0;
      v1       <= 1'b0;
      win1     <= 1'b0;
      cur1     <= 1'b0;
    end else begin
      char_row <= cell_row[ROW_W-1:0];
      char_col <= cell_col[COL_W-1:0];
      lx1      <= tx[GLYPH_W_LOG2-1:0];
      ly1      <= ty[GLYPH_H_LOG2-1:0];
      v1       <= pix_valid;
      win1     <= in_win_c;
      cur1     <= is_cur_c;
    end
  end

  // S2: capture the character code alongside the delayed offsets and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      code2 <= '0;
      lx2   <= '0;
      ly2   <= '0;
      v2    <= 1'b0;
      win2  <= 1'b0;
      cur2  <= 1'b0;
    end else begin
      code2 <= char_code;
      lx2   <= lx1;
      ly2   <= ly1;
      v2    <= v1;
      win2  <= win1;
      cur2  <= cur1;
    end
  end

  // S3: glyph ROM address is a pure concatenation since glyph dimensions are powers of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      glyph_addr <= '0;
      v3         <= 1'b0;
      win3       <= 1'b0;
      cur3       <= 1'b0;
    end else begin
      glyph_addr <= {code2, ly2, lx2};
      v3         <= v2;
      win3       <= win2;
      cur3       <= cur2;
    end
  end

  // S4: capture the texel colour returned by the glyph ROM.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix4 <= COLOR_BLACK;
      v4   <= 1'b0;
      win4 <= 1'b0;
      cur4 <= 1'b0;
    end else begin
      pix4 <= glyph_pixel;
      v4   <= v3;
      win4 <= win3;
      cur4 <= cur3;
    end
  end

  // S5: blanking, window background and blinking inverse-video cursor.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb       <= COLOR_BLACK;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= v4;
      if (!v4) begin
        rgb <= COLOR_BLACK;
      end else if (!win4) begin
        rgb <= BG_COLOR;
      end else if (cur4 && !blink_phase) begin
        rgb <= invert_rgb(pix4);
      end else begin
        rgb <= pix4;
      end
    end
  end

endmodule

// File: tb/tb_text_pixel_renderer.sv
// tb/tb_text_pixel_renderer.sv - directed table-driven bench for text_pixel_renderer
module tb_text_pixel_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic [9:0]  x, y;
  logic        frame_tick;
  logic        cursor_en;
  logic [3:0]  cursor_row;
  logic [5:0]  cursor_col;
  logic [3:0]  char_row;
  logic [5:0]  char_col;
  logic [7:0]  char_code;
  logic [16:0] glyph_addr;
  logic [11:0] glyph_pixel;
  logic [11:0] rgb;
  logic        rgb_valid;

  logic [7:0]  code_val;
  logic [11:0] pix_val;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        cen;
    logic [7:0]  code;
    logic [11:0] pix;
    logic [3:0]  erow;
    logic [5:0]  ecol;
    logic [16:0] eaddr;
    logic [11:0] ergb;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  assign char_code   = code_val;
  assign glyph_pixel = pix_val;

  text_pixel_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .x          (x),
    .y          (y),
    .frame_tick (frame_tick),
    .cursor_en  (cursor_en),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .char_row   (char_row),
    .char_col   (char_col),
    .char_code  (char_code),
    .glyph_addr (glyph_addr),
    .glyph_pixel(glyph_pixel),
    .rgb        (rgb),
    .rgb_valid  (rgb_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick_frame();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic run_pixel(input vec_t v, input string name);
    @(negedge clk);
    pix_valid = 1'b1;
    x         = v.x;
    y         = v.y;
    cursor_en = v.cen;
    code_val  = v.code;
    pix_val   = v.pix;
    @(posedge clk); #1;
    check({name, ".char_row"}, 32'(char_row), 32'(v.erow));
    check({name, ".char_col"}, 32'(char_col), 32'(v.ecol));
    pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({name, ".glyph_addr"}, 32'(glyph_addr), 32'(v.eaddr));
    repeat (2) @(posedge clk);
    #1;
    check({name, ".rgb_valid"}, 32'(rgb_valid), 32'd1);
    check({name, ".rgb"}, 32'(rgb), 32'(v.ergb));
  endtask

  initial begin
    vec_t cv;

    //           x     y     cen   code   pix      row  col   addr       rgb
    vecs[0] = '{10'd0,   10'd0,   1'b0, 8'h41, 12'hABC, 4'd0,  6'd0,  17'h08200, 12'hABC};
    vecs[1] = '{10'd37,  10'd70,  1'b0, 8'h5A, 12'h123, 4'd1,  6'd1,  17'h0B432, 12'h123};
    vecs[2] = '{10'd639, 10'd0,   1'b0, 8'h00, 12'h456, 4'd0,  6'd19, 17'h0000F, 12'h456};
    vecs[3] = '{10'd0,   10'd479, 1'b0, 8'h33, 12'h789, 4'd7,  6'd0,  17'h066F0, 12'h00F};
    vecs[4] = '{10'd37,  10'd70,  1'b1, 8'h20, 12'h0F0, 4'd1,  6'd1,  17'h04032, 12'hF0F};
    vecs[5] = '{10'd640, 10'd0,   1'b0, 8'h11, 12'hFFF, 4'd0,  6'd20, 17'h02200, 12'h00F};
    vecs[6] = '{10'd1023,10'd1023,1'b1, 8'h7F, 12'h321, 4'd15, 6'd31, 17'h0FFFF, 12'h00F};
    vecs[7] = '{10'd64,  10'd70,  1'b1, 8'h01, 12'h0F0, 4'd1,  6'd2,  17'h00230, 12'h0F0};

    reset      = 1'b1;
    pix_valid  = 1'b0;
    x          = '0;
    y          = '0;
    frame_tick = 1'b0;
    cursor_en  = 1'b0;
    cursor_row = 4'd1;
    cursor_col = 6'd1;
    code_val   = '0;
    pix_val    = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset.rgb", 32'(rgb), 32'h0);
    check("reset.rgb_valid", 32'(rgb_valid), 32'h0);
    check("reset.char_row", 32'(char_row), 32'h0);
    check("reset.char_col", 32'(char_col), 32'h0);
    check("reset.glyph_addr", 32'(glyph_addr), 32'h0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_pixel(vecs[i], $sformatf("vec%0d", i));
    end

    // Blink: phase flips only on the 30th tick of a half-period.
    cv = vecs[4];
    for (int i = 0; i < 29; i++) tick_frame();
    run_pixel(cv, "blink29");
    tick_frame();
    cv.ergb = 12'h0F0;
    run_pixel(cv, "blink30");
    for (int i = 0; i < 30; i++) tick_frame();
    cv.ergb = 12'hF0F;
    run_pixel(cv, "blink60");

    // Mid-stream reset with a coincident frame_tick; phase is moved to 1 first.
    for (int i = 0; i < 30; i++) tick_frame();
    @(negedge clk);
    pix_valid = 1'b1;
    x         = 10'd37;
    y         = 10'd70;
    cursor_en = 1'b1;
    code_val  = 8'h20;
    pix_val   = 12'h0F0;
    repeat (6) @(posedge clk);
    #1;
    check("stream.pre_rgb", 32'(rgb), 32'h0F0);
    @(negedge clk);
    reset      = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    check("stream.rst_valid", 32'(rgb_valid), 32'h0);
    check("stream.rst_rgb", 32'(rgb), 32'h0);
    @(negedge clk);
    reset      = 1'b0;
    frame_tick = 1'b0;
    pix_valid  = 1'b0;
    repeat (2) @(negedge clk);
    pix_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("stream.early_valid", 32'(rgb_valid), 32'h0);
    @(posedge clk); #1;
    check("stream.resume_valid", 32'(rgb_valid), 32'h1);
    check("stream.resume_rgb", 32'(rgb), 32'hF0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
